u_idu_dispatcher: RTL

- In-order dual-slot dispatcher between the instruction buffer (u_idu_instBuffer) and IEX.
- Consumes the buffer's two head entries and returns dispatch_vld_0/1 pops. Holds the 2-entry issue register to IEX.
- Detects exceptions/WFI and raises dispatcher_detect_exceptions_wfi, which clears the buffer and stalls IFU.
- Sequences halt and restart with IEX and CSR.

---
 rtl/u_idu_dispatcher.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/u_idu_dispatcher.sv
// In-order dual-slot dispatcher: pops the instruction buffer head, holds the IEX issue register
// and sequences exception/WFI halt and restart. Optional macro DISPATCHER_DUAL_ISSUE_EN enables slot 1.
module u_idu_dispatcher #(
    parameter int PC_WIDTH      = 32,
    parameter int INST_WIDTH    = 32,
    parameter int EXCEPTION_NUM = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync_start_pulse,
    input  logic [EXCEPTION_NUM-1:0] csr_core_configuration,
    input  logic                     instBuffer_inst_vld_0,
    input  logic                     instBuffer_inst_vld_1,
    input  logic [INST_WIDTH-1:0]    inst_in_0,
    input  logic [INST_WIDTH-1:0]    inst_in_1,
    input  logic [PC_WIDTH-1:0]      pc_in_0,
    input  logic [PC_WIDTH-1:0]      pc_in_1,
    input  logic                     unalign_pc_in_0,
    input  logic                     unalign_pc_in_1,
    input  logic                     bru_flush,
    input  logic                     iex_idu_ready,
    input  logic                     iex_ifu_report_exceptions_wfi,
    output logic                     dispatch_vld_0,
    output logic                     dispatch_vld_1,
    output logic                     dispatcher_detect_exceptions_wfi,
    output logic [1:0]               idu_iex_vld,
    output logic [INST_WIDTH-1:0]    idu_iex_inst_0,
    output logic [INST_WIDTH-1:0]    idu_iex_inst_1,
    output logic [PC_WIDTH-1:0]      idu_iex_pc_0,
    output logic [PC_WIDTH-1:0]      idu_iex_pc_1,
    output logic [EXCEPTION_NUM-1:0] idu_iex_exceptions,
    output logic                     idu_iex_wfi
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_RPT, S_HALT} state_t;

    localparam logic [INST_WIDTH-1:0] WFI_INST = INST_WIDTH'(32'h1050_0073);

    function automatic logic f_legal(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011: f_legal = 1'b1;
            default: f_legal = 1'b0;
        endcase
    endfunction

    state_t                   r_state, w_state_nxt;
    logic [1:0]               r_vld;
    logic [INST_WIDTH-1:0]    r_inst_0, r_inst_1;
    logic [PC_WIDTH-1:0]      r_pc_0, r_pc_1;
    logic [EXCEPTION_NUM-1:0] r_exc;
    logic                     r_wfi;

    logic [EXCEPTION_NUM-1:0] w_exc_0;
    logic                     w_wfi_0, w_exc_wfi_0, w_slot1_ok;

    // Disabled exceptions are simply masked off, so the instruction flows through as normal.
    always_comb begin
        w_exc_0    = '0;
        w_exc_0[0] = !f_legal(inst_in_0[6:0]) && csr_core_configuration[0];
        w_exc_0[1] = unalign_pc_in_0 && csr_core_configuration[1];
    end
    assign w_wfi_0     = (inst_in_0 == WFI_INST);
    assign w_exc_wfi_0 = (|w_exc_0) || w_wfi_0;

`ifdef DISPATCHER_DUAL_ISSUE_EN
    logic [6:0] w_op_0, w_op_1;
    logic [4:0] w_rd_0;
    logic       w_wr_0, w_raw, w_br_0, w_mem_both, w_exc_wfi_1;

    assign w_op_0 = inst_in_0[6:0];
    assign w_op_1 = inst_in_1[6:0];
    assign w_rd_0 = inst_in_0[11:7];
    assign w_wr_0 = (w_op_0 == 7'b0110111) || (w_op_0 == 7'b0010111) || (w_op_0 == 7'b1101111) ||
                    (w_op_0 == 7'b1100111) || (w_op_0 == 7'b0000011) || (w_op_0 == 7'b0010011) ||
                    (w_op_0 == 7'b0110011);
    assign w_raw  = w_wr_0 && (w_rd_0 != 5'd0) &&
                    ((w_rd_0 == inst_in_1[19:15]) || (w_rd_0 == inst_in_1[24:20]));
    assign w_br_0 = (w_op_0 == 7'b1100011) || (w_op_0 == 7'b1101111) || (w_op_0 == 7'b1100111);
    assign w_mem_both = ((w_op_0 == 7'b0000011) || (w_op_0 == 7'b0100011)) &&
                        ((w_op_1 == 7'b0000011) || (w_op_1 == 7'b0100011));
    assign w_exc_wfi_1 = (!f_legal(w_op_1) && csr_core_configuration[0]) ||
                         (unalign_pc_in_1 && csr_core_configuration[1]) || (inst_in_1 == WFI_INST);
    assign w_slot1_ok = instBuffer_inst_vld_1 && !w_raw && !w_br_0 && !w_mem_both &&
                        !w_exc_wfi_0 && !w_exc_wfi_1;
`else
    logic w_unused_slot1;
    assign w_unused_slot1 = ^{instBuffer_inst_vld_1, unalign_pc_in_1};
    assign w_slot1_ok     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (sync_start_pulse) w_state_nxt = S_RUN;
            S_RUN:          if (dispatcher_detect_exceptions_wfi) w_state_nxt = S_WAIT_RPT;
            S_WAIT_RPT:     if (iex_ifu_report_exceptions_wfi) w_state_nxt = S_HALT;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dispatch_vld_0                   = 1'b0;
        dispatch_vld_1                   = 1'b0;
        dispatcher_detect_exceptions_wfi = 1'b0;
        if (r_state == S_RUN && iex_idu_ready && !bru_flush && instBuffer_inst_vld_0) begin
            dispatch_vld_0                   = 1'b1;
            dispatch_vld_1                   = w_slot1_ok;
            dispatcher_detect_exceptions_wfi = w_exc_wfi_0;
        end
    end

    // A flush in RUN kills the issued group even while IEX is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_inst_0 <= '0;
            r_inst_1 <= '0;
            r_pc_0   <= '0;
            r_pc_1   <= '0;
            r_exc    <= '0;
            r_wfi    <= 1'b0;
        end else if (bru_flush && r_state == S_RUN) begin
            r_vld <= '0;
        end else if (iex_idu_ready) begin
            r_vld <= {dispatch_vld_1, dispatch_vld_0};
            if (dispatch_vld_0) begin
                r_inst_0 <= inst_in_0;
                r_pc_0   <= pc_in_0;
                r_exc    <= w_exc_0;
                r_wfi    <= w_wfi_0;
                r_inst_1 <= inst_in_1;
                r_pc_1   <= pc_in_1;
            end
        end
    end

    assign idu_iex_vld        = r_vld;
    assign idu_iex_inst_0     = r_inst_0;
    assign idu_iex_inst_1     = r_inst_1;
    assign idu_iex_pc_0       = r_pc_0;
    assign idu_iex_pc_1       = r_pc_1;
    assign idu_iex_exceptions = r_exc;
    assign idu_iex_wfi        = r_wfi;

endmodule
